// File: rtl/chram_arbiter.sv
// Character/colour RAM port-A arbiter: Z80 pass-through writes plus a hardware screen fill engine.
// Latency: CPU writes reach the RAM ports combinationally; a fill writes one cell per cycle starting the cycle after fill_start.
// Backpressure: a running fill stalls CPU accesses to the CHR/COL regions via cpu_wait_n; other accesses are never stalled.
// Build option: define CHRAM_FILL_COLOR_EN to make the fill also write the latched colour into colour RAM.

module chram_arbiter #(
   parameter int FILL_WORDS = 2048
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_mreq_n,
   input  logic        cpu_wr_n,
   output logic        cpu_wait_n,
   input  logic        fill_start,
   input  logic        fill_abort,
   input  logic [7:0]  fill_char,
   input  logic [7:0]  fill_color,
   output logic        fill_busy,
   output logic        fill_done,
   output logic [10:0] ram_addr,
   output logic [7:0]  chram_data,
   output logic [7:0]  colram_data,
   output logic        chram_wr,
   output logic        colram_wr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [10:0] LAST_CELL = 11'(FILL_WORDS - 1);

   state_t      state, state_nx, state_eff;
   logic [10:0] cnt, cnt_nx;
   logic [7:0]  char_q, char_nx;
   logic [7:0]  color_q, color_nx;

   logic        chr_sel, col_sel, cpu_hit, cpu_wr;

   // Address decode of the two 2 KiB windows at 0x8000 and 0x8800.
   always_comb begin
      chr_sel = (cpu_addr[15:11] == 5'b10000);
      col_sel = (cpu_addr[15:11] == 5'b10001);
      cpu_hit = !cpu_mreq_n && (chr_sel || col_sel);
      cpu_wr  = !cpu_wr_n && !cpu_mreq_n;
   end

   // Next-state and output decode; reset cycles are decoded as IDLE so CPU writes still land.
   always_comb begin
      state_eff   = reset ? IDLE : state;
      state_nx    = state;
      cnt_nx      = cnt;
      char_nx     = char_q;
      color_nx    = color_q;
      ram_addr    = cpu_addr[10:0];
      chram_data  = cpu_dout;
      colram_data = cpu_dout;
      chram_wr    = cpu_wr && chr_sel;
      colram_wr   = cpu_wr && col_sel;
      cpu_wait_n  = 1'b1;
      fill_busy   = 1'b0;
      fill_done   = 1'b0;

      case (state_eff)
         IDLE: begin
            // fill_start wins over a simultaneous fill_abort
            if (fill_start) begin
               state_nx = FILL;
               cnt_nx   = 11'd0;
               char_nx  = fill_char;
               color_nx = fill_color;
            end
         end
         FILL: begin
            fill_busy   = 1'b1;
            cpu_wait_n  = !cpu_hit;
            ram_addr    = cnt;
            chram_data  = char_q;
            chram_wr    = 1'b0;
            colram_wr   = 1'b0;
`ifdef CHRAM_FILL_COLOR_EN
            colram_data = color_q;
`endif
            if (fill_abort) begin
               // Abort suppresses this cycle's write and skips the done pulse
               state_nx = IDLE;
            end else begin
               chram_wr = 1'b1;
`ifdef CHRAM_FILL_COLOR_EN
               colram_wr = 1'b1;
`endif
               if (cnt == LAST_CELL) begin
                  // Hold the counter on the last cell rather than wrapping
                  state_nx = DONE;
               end else begin
                  cnt_nx = cnt + 11'd1;
               end
            end
         end
         DONE: begin
            fill_done = 1'b1;
            state_nx  = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

`ifndef CHRAM_FILL_COLOR_EN
   // Colour latch exists in both builds but only feeds the RAM when colour fill is enabled.
   logic unused_color;
   assign unused_color = ^color_q;
`endif

   // State, cell counter and latched fill values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 11'd0;
         char_q  <= 8'd0;
         color_q <= 8'd0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         char_q  <= char_nx;
         color_q <= color_nx;
      end
   end

endmodule

// File: doc/chram_arbiter.md
CHRAM_ARBITER -- requirements
Module: chram_arbiter

Interface
REQ-001 Parameter FILL_WORDS, default 2048: number of character/colour cells written per fill, range 1..2048.
REQ-002 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_addr  in  16  Z80 address bus.
REQ-005 cpu_dout  in  8  Z80 write data.
REQ-006 cpu_mreq_n / cpu_wr_n  in  1 each  Z80 memory request and write strobes, active-low.
REQ-007 cpu_wait_n  out  1  Z80 wait request, active-low.
REQ-008 fill_start  in  1  one-cycle request to start a screen fill.
REQ-009 fill_abort  in  1  one-cycle request to cancel a running fill.
REQ-010 fill_char / fill_color  in  8 each  fill values, sampled on an accepted fill_start.
REQ-011 fill_busy  out  1  high while a fill is running.
REQ-012 fill_done  out  1  one-cycle pulse when a fill completes normally.
REQ-013 ram_addr  out  11  port-A address shared by char RAM and colour RAM.
REQ-014 chram_data / colram_data  out  8 each  port-A write data for char RAM and colour RAM.
REQ-015 chram_wr / colram_wr  out  1 each  port-A write enables.

Function
REQ-016 Region decode:
- CHR region = cpu_addr[15:11] == 5'b10000.
- COL region = cpu_addr[15:11] == 5'b10001.
- cpu_hit = !cpu_mreq_n && (CHR or COL).
REQ-017 State machine states are IDLE, FILL and DONE.
REQ-018 IDLE behaviour:
- ram_addr = cpu_addr[10:0].
- chram_data = colram_data = cpu_dout.
- chram_wr = !cpu_wr_n && !cpu_mreq_n && CHR.
- colram_wr = !cpu_wr_n && !cpu_mreq_n && COL.
- All of the above are combinational pass-through; cpu_wait_n = 1.
REQ-019 fill_start in IDLE:
- Latches fill_char and fill_color.
- Clears the 11-bit cell counter.
- Moves to FILL on the next edge.
- A CPU write present in that same cycle is still performed as a pass-through write.
REQ-020 FILL behaviour, every cycle:
- ram_addr = counter, chram_data = latched char, chram_wr = 1.
- The counter increments by 1.
- CPU writes are never forwarded to the RAM ports.
REQ-021 FILL has priority over the CPU: cpu_wait_n = !cpu_hit combinationally while in FILL; CPU accesses outside the CHR/COL regions are never stalled.
REQ-022 FILL to DONE: when a write occurs with counter == FILL_WORDS-1, the state moves to DONE; the counter never wraps past FILL_WORDS-1.
REQ-023 DONE behaviour:
- fill_done = 1 for exactly one cycle, then IDLE.
- Outputs behave as in IDLE.
- cpu_wait_n = 1.
REQ-024 Fill timing: fill_start accepted at cycle N gives the following.
- Cell 0 is written at N+1.
- The last cell is written at N+FILL_WORDS.
- fill_done pulses at N+FILL_WORDS+1.
- fill_busy is high for cycles N+1..N+FILL_WORDS inclusive.
REQ-025 fill_start while in FILL or DONE is ignored and the latched values are unchanged.
REQ-026 fill_abort:
- In FILL, fill_abort suppresses the write of that cycle and returns to IDLE on the next edge with no fill_done pulse.
- In IDLE or DONE, fill_abort is ignored.
- fill_start and fill_abort in the same IDLE cycle: fill_start wins.
REQ-027 A CPU stalled by wait proceeds in the first IDLE/DONE cycle with pass-through as in REQ-018, so no CPU write is lost.

Reset
REQ-028 While reset is high, on each clk_sys edge:
- state = IDLE, counter = 0, latched char = 0, latched colour = 0.
- fill_busy = 0, fill_done = 0, cpu_wait_n = 1.
REQ-029 Reset during FILL aborts the fill at the next edge with no fill_done pulse; cells already written are not restored.
REQ-030 Pass-through writes in reset cycles are decoded as in IDLE (REQ-018).

Configuration
REQ-031 Macro CHRAM_FILL_COLOR_EN controls colour-RAM filling.
- Defined: in FILL, colram_data = latched colour and colram_wr = 1 alongside chram_wr.
- Not defined: colram_wr = 0 throughout FILL, colour RAM is untouched, and fill_color is ignored.
- IDLE pass-through behaviour is identical in both builds.

Verification
REQ-032 IDLE, CPU write at 0x8005 data 0x41 -> chram_wr=1, colram_wr=0, ram_addr=0x005, chram_data=0x41 the same cycle; a write at 0x8805 -> colram_wr=1, chram_wr=0.
REQ-033 FILL_WORDS=16, fill_start at N with char 0x20, colour 0xC7 -> the following, with colram_wr=1 at the same cycles only if CHRAM_FILL_COLOR_EN is defined:
- chram_wr=1 at N+1..N+16.
- ram_addr 0..15.
- fill_done=1 only at N+17.
- fill_busy high N+1..N+16.
REQ-034 During FILL:
- CPU mreq at 0x8400 -> cpu_wait_n=0 until DONE; the CPU write then lands at 0x400 with its own data.
- CPU mreq at 0xC000 -> cpu_wait_n=1 throughout.
REQ-035 fill_abort at the 5th FILL cycle -> 4 cells written, IDLE next cycle, no fill_done; a new fill_start then starts again from address 0.
REQ-036 reset asserted mid-FILL -> next edge fill_busy=0, cpu_wait_n=1, fill_done never pulses; fill_start during FILL is ignored and the latched char is unchanged.
